// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller: FSM encoding, command
// byte layout and the pointer wrap helper.
package spi_reg_pkg;

   localparam int         ADDR_W       = 4;
   localparam logic [7:0] ERR_TX_BYTE  = 8'hFF;

   localparam int         CMD_RW_BIT   = 7;
   localparam int         CMD_RSV_MSB  = 6;
   localparam int         CMD_RSV_LSB  = 4;
   localparam int         CMD_ADDR_MSB = 3;
   localparam int         CMD_ADDR_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_WR   = 3'd2,
      ST_RD   = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   // Burst pointer advance, wrapping from the last implemented register to 0.
   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] i_ptr,
                                                 input int unsigned        i_num);
      if (32'(i_ptr) == (i_num - 1))
         return '0;
      else
         return i_ptr + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/spi_reg_ctrl_sync_2ff.sv
// Two-flop synchronizer for an asynchronous level; resets to 1 so an idle-high
// chip select reads as inactive while in reset.
module sync_2ff (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_D,
   output logic o_Q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_D;
         r_sync <= r_meta;
      end
   end

   assign o_Q = r_sync;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command decoder and burst sequencer between an SPI byte engine and a small
// register file, with SPI-priority arbitration against fabric host writes.
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int         NUM_REGS = 16,
   parameter logic [7:0] ID_BYTE  = 8'hA5
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst_L,
   input  logic                    i_SPI_CS_n,
   input  logic                    i_RX_DV,
   input  logic [7:0]              i_RX_Byte,
   output logic                    o_TX_DV,
   output logic [7:0]              o_TX_Byte,
   input  logic                    i_Host_Wr_En,
   input  logic [ADDR_W-1:0]       i_Host_Wr_Addr,
   input  logic [7:0]              i_Host_Wr_Data,
   output logic                    o_Host_Collision,
   output logic [NUM_REGS*8-1:0]   o_Regs,
   output logic                    o_Wr_Strobe,
   output logic [ADDR_W-1:0]       o_Wr_Addr,
   output logic [7:0]              o_Wr_Data,
   output logic [7:0]              o_Err_Cnt,
   output logic                    o_Busy
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic              w_cs_s;
   logic              r_cs_d;
   logic [2:0]        r_vld;
   logic              w_cs_fall;
   logic              w_cs_rise;

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] w_ptr_next;

   logic              w_cmd_rd;
   logic [2:0]        w_cmd_rsv;
   logic [ADDR_W-1:0] w_cmd_addr;
   logic              w_cmd_bad;

   logic              w_tx_dv;
   logic [7:0]        w_tx_byte;
   logic              w_spi_wr;
   logic              w_err_inc;

   logic              r_tx_dv;
   logic [7:0]        r_tx_byte;
   logic              r_wr_strobe;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;
   logic [7:0]        r_err_cnt;
   logic              r_busy;
   logic              r_collision;

   logic [7:0]        w_regs [NUM_REGS];

   sync_2ff u_cs_sync (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_D     (i_SPI_CS_n),
      .o_Q     (w_cs_s)
   );

   // r_vld gates fall detection until both cs_s and its delayed copy come from
   // the pin, so a CS_n already low at reset release never starts a transaction.
   assign w_cs_fall = r_vld[2] & r_cs_d & ~w_cs_s;
   assign w_cs_rise = ~r_cs_d & w_cs_s;

   assign w_cmd_rd   = i_RX_Byte[CMD_RW_BIT];
   assign w_cmd_rsv  = i_RX_Byte[CMD_RSV_MSB:CMD_RSV_LSB];
   assign w_cmd_addr = i_RX_Byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
   assign w_cmd_bad  = (w_cmd_rsv != 3'b000) || (int'(w_cmd_addr) >= NUM_REGS);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_cs_rise) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_cs_fall) w_state_next = ST_CMD;
            ST_CMD: begin
               if (i_RX_DV) begin
                  if (w_cmd_bad)
                     w_state_next = ST_ERR;
                  else if (w_cmd_rd)
                     w_state_next = ST_RD;
                  else
                     w_state_next = ST_WR;
               end
            end
            default: w_state_next = r_state;
         endcase
      end
   end

   always_comb begin
      w_tx_dv    = 1'b0;
      w_tx_byte  = r_tx_byte;
      w_spi_wr   = 1'b0;
      w_ptr_next = r_ptr;
      w_err_inc  = 1'b0;
      // A byte landing with the CS rise is dropped along with the transaction.
      if (!w_cs_rise) begin
         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) begin
                  w_tx_dv   = 1'b1;
                  w_tx_byte = ID_BYTE;
               end
            end
            ST_CMD: begin
               if (i_RX_DV) begin
                  if (w_cmd_bad) begin
                     w_err_inc = 1'b1;
                     w_tx_dv   = 1'b1;
                     w_tx_byte = ERR_TX_BYTE;
                  end else if (w_cmd_rd) begin
                     w_tx_dv    = 1'b1;
                     w_tx_byte  = w_regs[w_cmd_addr[IDX_W-1:0]];
                     w_ptr_next = ptr_inc(w_cmd_addr, NUM_REGS);
                  end else begin
                     w_ptr_next = w_cmd_addr;
                  end
               end
            end
            ST_WR: begin
               if (i_RX_DV) begin
                  w_spi_wr   = 1'b1;
                  w_tx_dv    = 1'b1;
                  w_tx_byte  = i_RX_Byte;
                  w_ptr_next = ptr_inc(r_ptr, NUM_REGS);
               end
            end
            ST_RD: begin
               if (i_RX_DV) begin
                  w_tx_dv    = 1'b1;
                  w_tx_byte  = w_regs[r_ptr[IDX_W-1:0]];
                  w_ptr_next = ptr_inc(r_ptr, NUM_REGS);
               end
            end
            default: w_tx_dv = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_cs_d      <= 1'b1;
         r_vld       <= 3'b000;
         r_ptr       <= '0;
         r_tx_dv     <= 1'b0;
         r_tx_byte   <= 8'h00;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= 8'h00;
         r_err_cnt   <= 8'h00;
         r_busy      <= 1'b0;
         r_collision <= 1'b0;
      end else begin
         r_cs_d      <= w_cs_s;
         r_vld       <= {r_vld[1:0], 1'b1};
         r_ptr       <= w_ptr_next;
         r_tx_dv     <= w_tx_dv;
         r_tx_byte   <= w_tx_byte;
         r_wr_strobe <= w_spi_wr;
         if (w_spi_wr) begin
            r_wr_addr <= r_ptr;
            r_wr_data <= i_RX_Byte;
         end
         if (w_err_inc && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
         r_busy      <= ~w_cs_s;
         r_collision <= w_spi_wr & i_Host_Wr_En;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic       w_spi_hit;
         logic       w_host_hit;
         logic [7:0] r_reg;

         assign w_spi_hit  = w_spi_wr && (int'(r_ptr) == gi);
         // Any SPI write, to any address, pre-empts the host in that cycle.
         assign w_host_hit = i_Host_Wr_En && !w_spi_wr && (int'(i_Host_Wr_Addr) == gi);

         always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L)
               r_reg <= 8'h00;
            else if (w_spi_hit)
               r_reg <= i_RX_Byte;
            else if (w_host_hit)
               r_reg <= i_Host_Wr_Data;
         end

         assign w_regs[gi]         = r_reg;
         assign o_Regs[8*gi +: 8]  = r_reg;
      end
   endgenerate

   assign o_TX_DV          = r_tx_dv;
   assign o_TX_Byte        = r_tx_byte;
   assign o_Wr_Strobe      = r_wr_strobe;
   assign o_Wr_Addr        = r_wr_addr;
   assign o_Wr_Data        = r_wr_data;
   assign o_Err_Cnt        = r_err_cnt;
   assign o_Busy           = r_busy;
   assign o_Host_Collision = r_collision;

endmodule
